// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an N-digit common-anode 7-seg display.
// Latency: all outputs registered, one clk after the state/input that produces them.
// Backpressure: one pending frame slot; o_load_ready low while it is full, freed at the frame boundary.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_enable            1 = scan, 0 = display dark and scan parked at digit 0
//   i_digits_in/i_dp_in BCD frame (digit i at [4i+3:4i]) and decimal points
//   i_load_valid        producer offers a frame; o_load_ready accepts it
//   o_bcd_out           shared decoder input, 4'hF = blank
//   o_an_n, o_dp_n      active-low anode enables and decimal point cathode
//   o_digit_idx         digit currently owning the slot
//   o_frame_done        1-cycle pulse on the last DRIVE cycle of the top digit
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int LZ_BLANK     = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_enable,
  input  logic [4*NUM_DIGITS-1:0]       i_digits_in,
  input  logic [NUM_DIGITS-1:0]         i_dp_in,
  input  logic                          i_load_valid,
  output logic                          o_load_ready,
  output logic [3:0]                    o_bcd_out,
  output logic [NUM_DIGITS-1:0]         o_an_n,
  output logic                          o_dp_n,
  output logic [$clog2(NUM_DIGITS)-1:0] o_digit_idx,
  output logic                          o_frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(CLK_DIV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GUARD = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_GUARD_END = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(NUM_DIGITS - 1);

  logic [1:0]                     r_state;
  logic [CNT_W-1:0]               r_cnt;
  logic [IDX_W-1:0]               r_idx;
  logic [NUM_DIGITS-1:0][3:0]     r_shadow_dig;
  logic [NUM_DIGITS-1:0]          r_shadow_dp;
  logic [NUM_DIGITS-1:0][3:0]     r_pend_dig;
  logic [NUM_DIGITS-1:0]          r_pend_dp;
  logic                           r_pend_full;

  logic [1:0]                     w_state_nxt;
  logic [CNT_W-1:0]               w_cnt_nxt;
  logic [IDX_W-1:0]               w_idx_nxt;
  logic                           w_frame_start;
  logic                           w_xfer;
  logic                           w_accept;
  logic                           w_pend_full_nxt;
  logic [NUM_DIGITS-1:0][3:0]     w_shadow_dig_nxt;
  logic [NUM_DIGITS-1:0]          w_shadow_dp_nxt;
  logic [NUM_DIGITS-1:0]          w_blank;
  logic                           w_zero_run;
  logic [NUM_DIGITS-1:0]          w_an_nxt;
  logic [3:0]                     w_bcd_nxt;
  logic                           w_dp_n_nxt;
  logic                           w_fd_nxt;

  // Slot sequencing. w_frame_start marks entry to the GUARD of digit 0.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_frame_start = 1'b0;
    if (!i_enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt   = S_GUARD;
          w_cnt_nxt     = '0;
          w_idx_nxt     = '0;
          w_frame_start = 1'b1;
        end
        S_GUARD: begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == CNT_GUARD_END) begin
            w_state_nxt = S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_GUARD;
            w_cnt_nxt   = '0;
            if (r_idx == IDX_LAST) begin
              w_idx_nxt     = '0;
              w_frame_start = 1'b1;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // Transfer and accept are mutually exclusive: accept needs an empty
  // pending slot, transfer needs a full one.
  assign w_xfer   = w_frame_start & r_pend_full;
  assign w_accept = i_load_valid & o_load_ready;

  always_comb begin
    w_pend_full_nxt = r_pend_full;
    if (w_xfer) begin
      w_pend_full_nxt = 1'b0;
    end else if (w_accept) begin
      w_pend_full_nxt = 1'b1;
    end
  end

  assign w_shadow_dig_nxt = w_xfer ? r_pend_dig : r_shadow_dig;
  assign w_shadow_dp_nxt  = w_xfer ? r_pend_dp  : r_shadow_dp;

  // Leading-zero blanking: walk down from the top digit while every digit
  // and decimal point seen so far is zero. Digit 0 is always shown.
  always_comb begin
    w_blank    = '0;
    w_zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run && (w_shadow_dig_nxt[i] == 4'h0) && !w_shadow_dp_nxt[i];
      w_blank[i] = (LZ_BLANK != 0) && w_zero_run;
    end
  end

  // Outputs are computed from next-state values so the registered pins line
  // up with the registered state.
  always_comb begin
    w_an_nxt   = '1;
    w_bcd_nxt  = 4'hF;
    w_dp_n_nxt = 1'b1;
    if (w_state_nxt == S_DRIVE && !w_blank[w_idx_nxt]) begin
      w_an_nxt[w_idx_nxt] = 1'b0;
      w_bcd_nxt           = w_shadow_dig_nxt[w_idx_nxt];
      w_dp_n_nxt          = ~w_shadow_dp_nxt[w_idx_nxt];
    end
    w_fd_nxt = (w_state_nxt == S_DRIVE) && (w_cnt_nxt == CNT_LAST) && (w_idx_nxt == IDX_LAST);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shadow_dig <= '0;
      r_shadow_dp  <= '0;
      r_pend_dig   <= '0;
      r_pend_dp    <= '0;
      r_pend_full  <= 1'b0;
      o_load_ready <= 1'b1;
      o_an_n       <= '1;
      o_bcd_out    <= 4'hF;
      o_dp_n       <= 1'b1;
      o_digit_idx  <= '0;
      o_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_shadow_dig <= w_shadow_dig_nxt;
      r_shadow_dp  <= w_shadow_dp_nxt;
      if (w_accept) begin
        r_pend_dig <= i_digits_in;
        r_pend_dp  <= i_dp_in;
      end
      r_pend_full  <= w_pend_full_nxt;
      o_load_ready <= ~w_pend_full_nxt;
      o_an_n       <= w_an_nxt;
      o_bcd_out    <= w_bcd_nxt;
      o_dp_n       <= w_dp_n_nxt;
      o_digit_idx  <= w_idx_nxt;
      o_frame_done <= w_fd_nxt;
    end
  end

endmodule
